// File: rtl/pad_ctrl_pkg.sv
// Shared types and register map for the pad control bank.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [11:0] CTRL_OFS = 12'h100;
    localparam logic [11:0] STAT_OFS = 12'h104;

    localparam int unsigned PAD_OEN_BIT = 0;
    localparam int unsigned PAD_REN_BIT = 1;

endpackage

// File: rtl/pad_ctrl_seq.sv
// Commit sequencer: walks the pads and emits per-pad load strobes.
// PAD_CTRL_STAGGER_EN selects staggered loading; otherwise all pads load at once.
module pad_ctrl_seq
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PADS = 44,
    parameter int unsigned STAGGER  = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic [NUM_PADS-1:0] o_load_c,
    output logic                o_busy_c,
    output logic                o_done_c
);

    state_e r_state, w_state_nx;

`ifdef PAD_CTRL_STAGGER_EN
    localparam int unsigned IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic [7:0]       r_gap, w_gap_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_gap   <= w_gap_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_gap_nx   = r_gap;
        o_load_c   = '0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nx = APPLY;
                    w_idx_nx   = '0;
                    w_gap_nx   = '0;
                end
            end
            APPLY: begin
                if (r_gap == 8'd0) begin
                    o_load_c[r_idx] = 1'b1;
                    if (r_idx == IDX_W'(NUM_PADS - 1)) begin
                        w_state_nx = DONE;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                        w_gap_nx = 8'(STAGGER - 1);
                    end
                end else begin
                    w_gap_nx = r_gap - 8'd1;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end
`else
    // Stagger spacing has no meaning when every pad loads in one cycle.
    logic w_unused_cfg;
    assign w_unused_cfg = ^8'(STAGGER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        o_load_c   = '0;
        case (r_state)
            IDLE:    if (i_start) w_state_nx = APPLY;
            APPLY: begin
                o_load_c   = '1;
                w_state_nx = DONE;
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end
`endif

    assign o_busy_c = (r_state != IDLE);
    assign o_done_c = (r_state == DONE);

endmodule

// File: rtl/pad_ctrl_bank.sv
// Wishbone-mapped pad oe_n/re_n shadow bank with a sequenced commit to the active pads.
// Build with PAD_CTRL_STAGGER_EN for staggered per-pad commits.
module pad_ctrl_bank
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned          NUM_PADS = 44,
    parameter int unsigned          STAGGER  = 4,
    parameter logic [NUM_PADS-1:0]  OEN_RST  = 44'h3C0_0FFF_FFBD,
    parameter logic [NUM_PADS-1:0]  REN_RST  = '1,
    parameter logic [19:0]          BASE_ADR = 20'h30006
)(
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NUM_PADS-1:0] oe_n,
    output logic [NUM_PADS-1:0] re_n,
    output logic                commit_done
);

    localparam int unsigned PIDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic [NUM_PADS-1:0] r_sh_oen, r_sh_ren, r_oen, r_ren, w_load;
    logic                r_ack, r_err;
    logic [31:0]         r_dat, w_rdata;
    logic                w_hit, w_acc, w_wr, w_busy, w_done, w_start;
    logic                w_is_pad, w_is_ctrl, w_is_stat;
    logic [11:0]         w_ofs;
    logic [9:0]          w_word;
    logic [PIDX_W-1:0]   w_pad;
    logic                w_unused;

    assign w_unused = ^{wbs_dat_i[31:2], wbs_sel_i[3:1]};

    // Decode; the ack register blocks acceptance in the cycle after an ack.
    assign w_hit     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADR);
    assign w_acc     = w_hit && !r_ack;
    assign w_wr      = w_acc && wbs_we_i;
    assign w_ofs     = wbs_adr_i[11:0];
    assign w_word    = w_ofs[11:2];
    assign w_pad     = w_word[PIDX_W-1:0];
    assign w_is_pad  = (w_ofs[1:0] == 2'b00) && (w_word < 10'(NUM_PADS));
    assign w_is_ctrl = (w_ofs == CTRL_OFS);
    assign w_is_stat = (w_ofs == STAT_OFS);
    assign w_start   = w_wr && w_is_ctrl && wbs_dat_i[0];

    always_comb begin
        w_rdata = '0;
        if (w_is_pad) begin
            w_rdata[PAD_OEN_BIT] = r_sh_oen[w_pad];
            w_rdata[PAD_REN_BIT] = r_sh_ren[w_pad];
        end else if (w_is_ctrl || w_is_stat) begin
            w_rdata[1:0] = {r_err, w_busy};
        end
    end

    pad_ctrl_seq #(
        .NUM_PADS (NUM_PADS),
        .STAGGER  (STAGGER)
    ) u_seq (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_start  (w_start),
        .o_load_c (w_load),
        .o_busy_c (w_busy),
        .o_done_c (w_done)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rdata : 32'h0;
            if (w_wr && w_is_pad && w_busy)
                r_err <= 1'b1;
            else if (w_wr && w_is_stat && wbs_dat_i[1])
                r_err <= 1'b0;
        end
    end

    // Shadow writes are frozen while a commit is walking the pads.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sh_oen <= OEN_RST;
            r_sh_ren <= REN_RST;
        end else if (w_wr && w_is_pad && wbs_sel_i[0] && !w_busy) begin
            r_sh_oen[w_pad] <= wbs_dat_i[PAD_OEN_BIT];
            r_sh_ren[w_pad] <= wbs_dat_i[PAD_REN_BIT];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_oen <= OEN_RST;
            r_ren <= REN_RST;
        end else begin
            r_oen <= (r_oen & ~w_load) | (r_sh_oen & w_load);
            r_ren <= (r_ren & ~w_load) | (r_sh_ren & w_load);
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign oe_n        = r_oen;
    assign re_n        = r_ren;
    assign commit_done = w_done;

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// Directed bench for pad_ctrl_bank; expectations follow PAD_CTRL_STAGGER_EN.
module tb_pad_ctrl_bank;

    localparam int unsigned N = 44;
    localparam int unsigned S = 4;
    localparam logic [N-1:0] OEN_RST = 44'h3C0_0FFF_FFBD;
`ifdef PAD_CTRL_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif
    // Edge (relative to the commit ack) after which the last pad is loaded.
    localparam int LAST_K = STAG ? 1 + (N - 1) * S : 1;
    localparam logic [31:0] BASE = 32'h3000_6000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   adr = 32'h0, wdat = 32'h0;
    logic          ack;
    logic [31:0]   rdat_o;
    logic [N-1:0]  oe_n, re_n;
    logic          done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    pad_ctrl_bank #(
        .NUM_PADS (N),
        .STAGGER  (S),
        .REN_RST  ({N{1'b0}})
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat_o),
        .oe_n        (oe_n),
        .re_n        (re_n),
        .commit_done (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic int upd_k(input int i);
        return STAG ? 1 + i * S : 1;
    endfunction

    // One Wishbone transfer, bounded to 8 cycles waiting for ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic got);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        got = 1'b0; rd = 32'h0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                rd  = rdat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (oe_n !== OEN_RST) begin bad++; $display("FAIL rst_oe_n: got %h want %h", oe_n, OEN_RST); end
        total++; if (re_n !== '0) begin bad++; $display("FAIL rst_re_n: got %h want 0", re_n); end
        total++; if (ack !== 1'b0 || done !== 1'b0 || rdat_o !== 32'h0) begin
            bad++; $display("FAIL rst_bus: ack=%b done=%b dat=%h want 0/0/0", ack, done, rdat_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rd_pad1: got %h want 0", rd); end
        wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL rd_pad0: got %h want 1", rd); end
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rd_ctrl_idle: got %h want 0", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic got;
        wb_xfer(1'b1, 32'h3000_7000, 32'h0, 4'hF, rd, got);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL miss_ack: got %b want 0", got); end
        wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL miss_effect: got %h want 1", rd); end
        wb_xfer(1'b1, BASE + 32'h200, 32'hFFFF_FFFF, 4'hF, rd, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL unmapped_ack: got %b want 1", got); end
        wb_xfer(1'b0, BASE + 32'h200, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %h want 0", rd); end
        // Byte lane 0 is required for a shadow write to land.
        wb_xfer(1'b1, BASE + 32'h08, 32'h2, 4'b0010, rd, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL sel_ack: got %b want 1", got); end
        wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL sel_noeffect: got %h want 1", rd); end
        wb_xfer(1'b1, BASE + 32'h08, 32'h3, 4'b0001, rd, got);
        wb_xfer(1'b1, BASE + 32'h04, 32'h3, 4'hF, rd, got);
        wb_xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL shadow_rd: got %h want 3", rd); end
        total++; if (oe_n !== OEN_RST || re_n !== '0) begin
            bad++; $display("FAIL active_before_commit: oe=%h re=%h want %h 0", oe_n, re_n, OEN_RST);
        end
    endtask

    task automatic test_commit();
        logic [31:0] rd;
        logic got;
        logic [N-1:0] sh_oe, sh_re, exp_oe, exp_re;
        int d0;
        sh_oe = OEN_RST; sh_oe[1] = 1'b1; sh_oe[2] = 1'b1;
        sh_re = '0;      sh_re[1] = 1'b1; sh_re[2] = 1'b1;
        d0 = done_cnt;
        wb_xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, rd, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL commit_ack: got %b want 1", got); end
        for (int k = 1; k <= LAST_K + 2; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                exp_oe[i] = (k >= upd_k(i)) ? sh_oe[i] : OEN_RST[i];
                exp_re[i] = (k >= upd_k(i)) ? sh_re[i] : 1'b0;
            end
            total++; if (oe_n !== exp_oe) begin bad++; $display("FAIL commit_oe k=%0d: got %h want %h", k, oe_n, exp_oe); end
            total++; if (re_n !== exp_re) begin bad++; $display("FAIL commit_re k=%0d: got %h want %h", k, re_n, exp_re); end
            total++; if (done !== (k == LAST_K)) begin bad++; $display("FAIL commit_done k=%0d: got %b want %b", k, done, (k == LAST_K)); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL commit_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_busy();
        logic [31:0] rd;
        logic got;
        int d0;
        d0 = done_cnt;
        wb_xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, rd, got);
        // Issued back to back, so it lands while the commit is still in flight.
        wb_xfer(1'b1, BASE + 32'h0C, 32'h2, 4'hF, rd, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL busy_wr_ack: got %b want 1", got); end
        wb_xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, rd, got);
        total++; if (rd !== (STAG ? 32'h3 : 32'h2)) begin bad++; $display("FAIL status_err: got %h want %h", rd, (STAG ? 32'h3 : 32'h2)); end
        wb_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL busy_shadow: got %h want 1", rd); end
        wb_xfer(1'b1, BASE + 32'h104, 32'h2, 4'hF, rd, got);
        wb_xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, rd, got);
        total++; if (rd !== (STAG ? 32'h1 : 32'h0)) begin bad++; $display("FAIL status_w1c: got %h want %h", rd, (STAG ? 32'h1 : 32'h0)); end
`ifdef PAD_CTRL_STAGGER_EN
        wb_xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, rd, got);
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL commit_while_busy: got %h want 1", rd); end
`endif
        repeat (LAST_K + 5) @(posedge clk);
        #1;
        wb_xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL status_idle: got %h want 0", rd); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL busy_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            total++; if (ack !== j[0]) begin bad++; $display("FAIL b2b_ack j=%0d: got %b want %b", j, ack, j[0]); end
            if (j[0]) begin
                total++; if (rdat_o !== 32'h1) begin bad++; $display("FAIL b2b_dat j=%0d: got %h want 1", j, rdat_o); end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_commit();
        logic [31:0] rd;
        logic got;
        int d0;
        wb_xfer(1'b1, BASE + 32'h10, 32'h2, 4'hF, rd, got);
        d0 = done_cnt;
        wb_xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, rd, got);
        repeat (19) @(posedge clk);
        #1;
        total++; if (oe_n[4] !== 1'b0 || re_n[4] !== 1'b1) begin
            bad++; $display("FAIL pad4_applied: oe=%b re=%b want 0 1", oe_n[4], re_n[4]);
        end
        rst = 1'b1;
        #1;
        total++; if (oe_n !== OEN_RST || re_n !== '0) begin
            bad++; $display("FAIL abort_pads: oe=%h re=%h want %h 0", oe_n, re_n, OEN_RST);
        end
        total++; if (done !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL abort_ctl: done=%b ack=%b want 0 0", done, ack); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAST_K + 10) @(posedge clk);
        #1;
        total++; if (oe_n !== OEN_RST || re_n !== '0) begin
            bad++; $display("FAIL abort_stays: oe=%h re=%h want %h 0", oe_n, re_n, OEN_RST);
        end
        total++; if (done_cnt - d0 !== (STAG ? 0 : 1)) begin
            bad++; $display("FAIL abort_pulses: got %0d want %0d", done_cnt - d0, (STAG ? 0 : 1));
        end
        wb_xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_status: got %h want 0", rd); end
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, got);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL abort_shadow: got %h want 1", rd); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_commit();
        test_busy();
        test_back_to_back();
        test_reset_mid_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
